// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-frame instruction cache with a blocking miss FSM
module icache #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);
    localparam int IW = $clog2(SETS);
    localparam int TW = 30 - IW;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t          state_q, state_d;
    logic [31:0]     miss_addr_q, miss_addr_d;
    logic            iren_q, iren_d;
    logic [31:0]     iaddr_q, iaddr_d;
    logic [SETS-1:0] valid_q;
    logic [TW-1:0]   tag_q  [SETS];
    logic [31:0]     data_q [SETS];

    logic [IW-1:0]   req_idx, miss_idx;
    logic [TW-1:0]   req_tag, miss_tag;
    logic            fill;
    logic            unused_bits;

    assign req_idx     = imemaddr[IW+1:2];
    assign req_tag     = imemaddr[31:IW+2];
    assign miss_idx    = miss_addr_q[IW+1:2];
    assign miss_tag    = miss_addr_q[31:IW+2];
    assign unused_bits = ^{imemaddr[1:0], miss_addr_q[1:0]};

    // Hit detection and data return; lookup is suppressed while a fill is in flight
    always_comb begin
        ihit     = imemREN && (state_q == IDLE) && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
        imemload = ihit ? data_q[req_idx] : 32'h0;
        fill     = (state_q == FETCH) && !iwait;
        iREN     = iren_q;
        iaddr    = iaddr_q;
    end

    // Next-state: a miss latches the word address and raises the request; the fill drops it
    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        iren_d      = iren_q;
        iaddr_d     = iaddr_q;
        if (state_q == IDLE && imemREN && !ihit) begin
            state_d     = FETCH;
            miss_addr_d = {imemaddr[31:2], 2'b00};
            iren_d      = 1'b1;
            iaddr_d     = {imemaddr[31:2], 2'b00};
        end else if (fill) begin
            state_d = IDLE;
            iren_d  = 1'b0;
            iaddr_d = 32'h0;
        end
    end

    // Control state and registered memory-side outputs; reset abandons any fill
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            miss_addr_q <= 32'h0;
            iren_q      <= 1'b0;
            iaddr_q     <= 32'h0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            iren_q      <= iren_d;
            iaddr_q     <= iaddr_d;
        end
    end

    // Valid bits: only these need clearing, tag/data are meaningless without them
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) valid_q <= '0;
        else if (fill) valid_q[miss_idx] <= 1'b1;
    end

    // Tag and data arrays: a fill overwrites the frame unconditionally (read-only memory)
    always_ff @(posedge CLK) begin
        if (fill) begin
            tag_q[miss_idx]  <= miss_tag;
            data_q[miss_idx] <= iload;
        end
    end
endmodule
